warmboot_ctrl: RTL and testbench
================================

Name: warmboot_ctrl

Overview:
- Receiving end of the warmboot tile's BOOT/SLOT fabric outputs.
- Synchronises BOOT and SLOT from fabric routing, qualifies a BOOT assertion, and latches the selected slot.
- Issues a req/ack handshake to the configuration loader so it reloads the bitstream from that slot.
- Sits in the fabric top level between the S_WARMBOOT tile outputs and the bitstream configuration controller.

Parameters:
- SLOT_WIDTH, 4: width of SLOT and boot_slot.
- SYNC_STAGES, 2: flop stages on BOOT and SLOT inputs, minimum 2.
- HOLD_CYCLES, 4: consecutive synced-high cycles of BOOT, with SLOT unchanged, needed to qualify a request; minimum 1.
- TIMEOUT_CYCLES, 1023: cycles in REQ without boot_ack before abort; 0 disables the timeout.

Ports:
- CLK  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- BOOT  in  1  warmboot trigger from fabric; asynchronous to CLK.
- SLOT  in  SLOT_WIDTH  slot select from fabric; asynchronous to CLK.
- boot_ack  in  1  loader acknowledge, level; synchronous to CLK.
- boot_req  out  1  request to loader.
- boot_slot  out  SLOT_WIDTH  latched slot; valid while boot_req=1.
- busy  out  1  high in QUAL, REQ, DONE.
- timeout_err  out  1  sticky; set on handshake timeout.

Behaviour:
- Reset: all outputs 0, all sync flops 0, counters 0, state WAIT_LOW.
- resetn deassertion is synchronised internally (2 flops) before leaving WAIT_LOW.
- bs and ss denote the synced BOOT and SLOT. Input-to-bs latency is SYNC_STAGES cycles. SLOT uses identical staging.
- WAIT_LOW: waits for bs=0, then goes to ARMED. A BOOT held high through reset therefore never triggers.
- ARMED: on bs=1, goes to QUAL, loads hold_cnt=1 and captures cap_slot=ss.
- QUAL: each cycle with bs=1:
  - If ss==cap_slot, increment hold_cnt.
  - If ss!=cap_slot, set cap_slot=ss and hold_cnt=1 (restart).
  - When hold_cnt reaches HOLD_CYCLES, go to REQ. boot_slot is loaded with cap_slot on the same edge.
  - bs=0 at any point returns to ARMED, with no request and no error.
- REQ:
  - boot_req=1; boot_slot is held constant.
  - Timeout counter increments each cycle.
  - boot_ack=1 goes to DONE.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES before ack: set timeout_err, drop boot_req, go to WAIT_LOW.
  - If ack and timeout occur on the same cycle, ack wins.
- DONE:
  - boot_req=0, busy=1.
  - Waits for boot_ack=0 and bs=0 together, then goes to ARMED.
  - One BOOT assertion yields exactly one request.
- boot_req is a registered output, changing only on CLK edges.
  - Minimum BOOT-pin-high to boot_req latency: SYNC_STAGES + HOLD_CYCLES cycles.
- boot_ack seen in any state other than REQ is ignored.
- timeout_err is cleared only by resetn.
- Asynchronous reset mid-handshake drops boot_req immediately (combinationally via flop reset). The loader must tolerate this.
- The HOLD_CYCLES=1 boundary: the transition to REQ occurs on the first QUAL cycle.
- Counter widths: $clog2 of the parameter + 1. No wrap inside a legal state.

Test Plan:
- Reset with BOOT=1 held, then release resetn and keep BOOT=1 for 50 cycles -> boot_req stays 0 and state stays WAIT_LOW. Drop BOOT, raise it again with SLOT=4'h5 -> boot_req=1 and boot_slot=4'h5 after exactly 2+4 cycles from the pin edge.
- BOOT pulse 3 cycles (HOLD_CYCLES=4), SLOT=4'h2 -> no boot_req; busy high for the pulse only, then 0.
- BOOT=1, SLOT changes 4'h1 to 4'h3 on the 2nd qualifying cycle -> count restarts; boot_req asserts 4 cycles after the change with boot_slot=4'h3.
- In REQ, assert boot_ack 7 cycles later -> boot_req falls on the next edge. Hold ack and BOOT high 10 cycles -> no second request. Drop both -> ARMED. A new BOOT yields a new request.
- TIMEOUT_CYCLES=16, never ack -> boot_req drops after 16 cycles and timeout_err=1 sticky. Ack arriving on cycle 16 instead -> DONE, timeout_err=0.
- Pull resetn low while boot_req=1 -> boot_req, busy and boot_slot go 0 without waiting for a CLK edge. After release, the still-high BOOT does not retrigger until it goes low.

Source files
------------

// File: rtl/warmboot_ctrl.sv
// Warmboot request controller: synchronises fabric BOOT/SLOT, qualifies a held BOOT,
// and runs a req/ack handshake with the configuration loader.
//   state    | meaning
//   WAIT_LOW | after reset or timeout; wait for BOOT low before arming
//   ARMED    | idle, waiting for a BOOT rising level
//   QUAL     | BOOT high, counting stable cycles with an unchanged SLOT
//   REQ      | boot_req high, waiting for boot_ack or timeout
//   DONE     | acknowledged; wait for ack and BOOT both low
module warmboot_ctrl #(
  parameter int SLOT_WIDTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  CLK,
  input  logic                  resetn,
  input  logic                  BOOT,
  input  logic [SLOT_WIDTH-1:0] SLOT,
  input  logic                  boot_ack,
  output logic                  boot_req,
  output logic [SLOT_WIDTH-1:0] boot_slot,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_WAIT_LOW, S_ARMED, S_QUAL, S_REQ, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              rst_sync_q;
  logic [SYNC_STAGES-1:0]  boot_sync_q;
  logic [SLOT_WIDTH-1:0]   slot_sync_q [SYNC_STAGES];
  logic [HW-1:0]           hold_q, hold_d, hold_nxt;
  logic [TW-1:0]           to_q, to_d, to_nxt;
  logic [SLOT_WIDTH-1:0]   cap_q, cap_d, slot_q, slot_d;
  logic                    req_q, req_d, terr_q, terr_d;
  logic                    bs, rst_ok;
  logic [SLOT_WIDTH-1:0]   ss;

  assign bs     = boot_sync_q[SYNC_STAGES-1];
  assign ss     = slot_sync_q[SYNC_STAGES-1];
  assign rst_ok = rst_sync_q[1];

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q  <= '0;
      boot_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) slot_sync_q[i] <= '0;
      state_q     <= S_WAIT_LOW;
      hold_q      <= '0;
      to_q        <= '0;
      cap_q       <= '0;
      slot_q      <= '0;
      req_q       <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      rst_sync_q  <= {rst_sync_q[0], 1'b1};
      boot_sync_q <= {boot_sync_q[SYNC_STAGES-2:0], BOOT};
      slot_sync_q[0] <= SLOT;
      for (int i = 1; i < SYNC_STAGES; i++) slot_sync_q[i] <= slot_sync_q[i-1];
      state_q     <= state_d;
      hold_q      <= hold_d;
      to_q        <= to_d;
      cap_q       <= cap_d;
      slot_q      <= slot_d;
      req_q       <= req_d;
      terr_q      <= terr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    to_d     = to_q;
    cap_d    = cap_q;
    slot_d   = slot_q;
    req_d    = 1'b0;
    terr_d   = terr_q;
    // A slot change restarts qualification at one cycle with the new slot.
    hold_nxt = (ss == cap_q) ? hold_q + 1'b1 : HW'(1);
    to_nxt   = to_q + 1'b1;
    case (state_q)
      S_WAIT_LOW: begin
        if (rst_ok && !bs) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (bs) begin
          state_d = S_QUAL;
          hold_d  = HW'(1);
          cap_d   = ss;
        end
      end
      S_QUAL: begin
        if (!bs) begin
          state_d = S_ARMED;
          hold_d  = '0;
        end else begin
          hold_d = hold_nxt;
          cap_d  = ss;
          if (hold_nxt >= HOLD_MAX) begin
            state_d = S_REQ;
            slot_d  = ss;
            req_d   = 1'b1;
            to_d    = '0;
          end
        end
      end
      S_REQ: begin
        req_d = 1'b1;
        if (TIMEOUT_CYCLES != 0) to_d = to_nxt;
        if (boot_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
        end else if (TIMEOUT_CYCLES != 0 && to_nxt == TO_MAX) begin
          state_d = S_WAIT_LOW;
          req_d   = 1'b0;
          terr_d  = 1'b1;
        end
      end
      S_DONE: begin
        if (!boot_ack && !bs) state_d = S_ARMED;
      end
      default: state_d = S_WAIT_LOW;
    endcase
  end

  assign boot_req    = req_q;
  assign boot_slot   = slot_q;
  assign timeout_err = terr_q;
  assign busy        = (state_q == S_QUAL) || (state_q == S_REQ) || (state_q == S_DONE);

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Directed bench for warmboot_ctrl; requested slots are checked by a scoreboard
// monitor on each boot_req rising edge, timing/flags checked inline.
module tb_warmboot_ctrl;

  logic       CLK = 1'b0;
  logic       resetn;
  logic       BOOT;
  logic [3:0] SLOT;
  logic       boot_ack;
  logic       boot_req;
  logic [3:0] boot_slot;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [$];

  warmboot_ctrl #(
    .SLOT_WIDTH(4), .SYNC_STAGES(2), .HOLD_CYCLES(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .resetn(resetn), .BOOT(BOOT), .SLOT(SLOT), .boot_ack(boot_ack),
    .boot_req(boot_req), .boot_slot(boot_slot), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Scoreboard monitor: each new request must match the oldest expected slot.
  initial begin
    logic prev;
    logic [3:0] e;
    prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (boot_req && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req got slot=%0h exp no request", boot_slot);
        end else begin
          e = exp_q.pop_front();
          check("req_slot", boot_slot, e);
        end
      end
      prev = boot_req;
    end
  end

  initial begin
    resetn = 1'b0; BOOT = 1'b1; SLOT = 4'h0; boot_ack = 1'b0;
    step(3);
    check("rst_req", boot_req, 0);
    check("rst_busy", busy, 0);
    check("rst_slot", boot_slot, 0);
    check("rst_terr", timeout_err, 0);

    // BOOT held through reset must not trigger
    resetn = 1'b1;
    step(50);
    check("held_boot_req", boot_req, 0);
    check("held_boot_busy", busy, 0);
    BOOT = 1'b0;
    step(5);
    SLOT = 4'h5; BOOT = 1'b1; exp_q.push_back(4'h5);
    step(5);
    check("lat_req_before", boot_req, 0);
    step(1);
    check("lat_req_at", boot_req, 1);
    boot_ack = 1'b1;
    step(1);
    check("ack_drop", boot_req, 0);
    boot_ack = 1'b0; BOOT = 1'b0;
    step(5);
    check("armed_busy", busy, 0);

    // short pulse: qualified 3 cycles, never requests
    SLOT = 4'h2; BOOT = 1'b1;
    step(3);
    BOOT = 1'b0;
    step(1);
    check("pulse_busy", busy, 1);
    step(5);
    check("pulse_busy_end", busy, 0);
    check("pulse_req", boot_req, 0);

    // slot change restarts qualification
    SLOT = 4'h1; BOOT = 1'b1;
    step(3);
    SLOT = 4'h3; exp_q.push_back(4'h3);
    step(5);
    check("restart_req_before", boot_req, 0);
    step(1);
    check("restart_req_at", boot_req, 1);

    // ack 7 cycles into REQ, then hold ack+BOOT
    step(6);
    check("req_hold", boot_req, 1);
    boot_ack = 1'b1;
    step(1);
    check("ack7_drop", boot_req, 0);
    check("done_busy", busy, 1);
    step(10);
    check("done_no_req", boot_req, 0);
    check("done_busy_hold", busy, 1);
    boot_ack = 1'b0; BOOT = 1'b0;
    step(4);
    check("back_armed", busy, 0);
    SLOT = 4'h9; BOOT = 1'b1; exp_q.push_back(4'h9);
    step(6);
    check("second_req", boot_req, 1);
    boot_ack = 1'b1;
    step(1);
    boot_ack = 1'b0; BOOT = 1'b0;
    step(5);

    // ack on the 16th REQ cycle beats the timeout
    SLOT = 4'hB; BOOT = 1'b1; exp_q.push_back(4'hB);
    step(6);
    check("to16_req", boot_req, 1);
    step(15);
    check("to16_still_req", boot_req, 1);
    boot_ack = 1'b1;
    step(1);
    check("to16_drop", boot_req, 0);
    check("to16_done_busy", busy, 1);
    check("to16_terr", timeout_err, 0);
    boot_ack = 1'b0; BOOT = 1'b0;
    step(5);

    // no ack: timeout after 16 REQ cycles
    SLOT = 4'hA; BOOT = 1'b1; exp_q.push_back(4'hA);
    step(6);
    check("to_req", boot_req, 1);
    step(15);
    check("to_req_last", boot_req, 1);
    check("to_terr_before", timeout_err, 0);
    step(1);
    check("to_req_drop", boot_req, 0);
    check("to_terr", timeout_err, 1);
    check("to_busy", busy, 0);
    BOOT = 1'b0;
    step(5);
    check("to_terr_sticky", timeout_err, 1);

    // async reset during REQ
    SLOT = 4'hC; BOOT = 1'b1; exp_q.push_back(4'hC);
    step(6);
    check("ar_req", boot_req, 1);
    #2 resetn = 1'b0;
    #1;
    check("ar_req_drop", boot_req, 0);
    check("ar_busy", busy, 0);
    check("ar_slot", boot_slot, 0);
    check("ar_terr", timeout_err, 0);
    step(2);
    resetn = 1'b1;
    step(30);
    check("ar_no_retrigger", boot_req, 0);
    check("ar_no_busy", busy, 0);
    BOOT = 1'b0;
    step(5);
    SLOT = 4'hD; BOOT = 1'b1; exp_q.push_back(4'hD);
    step(6);
    check("ar_new_req", boot_req, 1);
    boot_ack = 1'b1;
    step(1);
    boot_ack = 1'b0; BOOT = 1'b0;
    step(5);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
